// File: rtl/writeback_unit_pkg.sv
// Writeback unit shared types: control bundle, load funct3 codes,
// FSM states and a natural-alignment helper for loads.
package writeback_unit_pkg;

  typedef struct packed {
    logic mem_read;
    logic wb_pc;
    logic reg_write;
  } control_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  // funct3[1:0] encodes the access size (byte/half/word/double)
  function automatic logic f3_misaligned(
    input logic [2:0] f3,
    input logic [2:0] off
  );
    logic m;
    m = 1'b0;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = |off[1:0];
      2'b11:   m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback request bundle: valid/ready handshake plus control,
// funct3, rd, pc and ALU result. master drives, slave accepts.
interface writeback_unit_if
  import writeback_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  control_t          in_control;
  logic [2:0]        in_funct3;
  logic [REG_AW-1:0] in_rd;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_alu_res;

  modport master (
    output in_valid, in_control, in_funct3,
    output in_rd, in_pc, in_alu_res,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_control, in_funct3,
    input  in_rd, in_pc, in_alu_res,
    output in_ready
  );
endinterface

// File: rtl/writeback_unit_load_extract.sv
// load_extract: combinational load size/sign extraction.
// Ports: i_data word, i_off byte offset, i_funct3 -> o_data, o_legal.
module load_extract
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OW  = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [OW-1:0]   i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data,
  output logic            o_legal
);

  // bytes shifted in from above the word read as zero
  logic [XLEN-1:0] w_sh;
  assign w_sh = i_data >> {i_off, 3'b000};

  always_comb begin
    o_data  = '0;
    o_legal = 1'b1;
    case (i_funct3)
      F3_LB:  o_data = XLEN'($signed(w_sh[7:0]));
      F3_LH:  o_data = XLEN'($signed(w_sh[15:0]));
      F3_LW:  o_data = XLEN'($signed(w_sh[31:0]));
      F3_LBU: o_data = XLEN'(w_sh[7:0]);
      F3_LHU: o_data = XLEN'(w_sh[15:0]);
      F3_LWU: begin
        if (XLEN == 64) o_data = XLEN'(w_sh[31:0]);
        else            o_legal = 1'b0;
      end
      F3_LD: begin
        if (XLEN == 64) o_data = w_sh;
        else            o_legal = 1'b0;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: IDLE/WAIT_MEM writeback FSM with registered rd port.
// Ports: clk, rst (async low), req (writeback_unit_if.slave),
//   mem_rsp_valid/data, rd_we/addr/data, busy.
// Macro WB_MISALIGN_TRAP_EN adds trap_misalign output.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  writeback_unit_if.slave   req,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
  output logic              rd_we,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_data,
`ifdef WB_MISALIGN_TRAP_EN
  output logic              trap_misalign,
`endif
  output logic              busy
);

  localparam int OW = $clog2(XLEN/8);

  wb_state_t         r_state;
  wb_state_t         w_next;
  logic [REG_AW-1:0] r_rd;
  logic [2:0]        r_f3;
  logic [OW-1:0]     r_off;
  logic              r_rw;

  logic              r_rd_we;
  logic [REG_AW-1:0] r_rd_addr;
  logic [XLEN-1:0]   r_rd_data;

  logic              w_complete;
  logic              w_is_load;
  logic              w_latch;
  logic              w_rw;
  logic [REG_AW-1:0] w_rd;
  logic [2:0]        w_f3;
  logic [OW-1:0]     w_off;
  logic [XLEN-1:0]   w_alu_data;
  logic [XLEN-1:0]   w_ld_data;
  logic              w_ld_legal;
  logic [XLEN-1:0]   w_data;
  logic              w_mis;
  logic              w_wr;

  load_extract #(.XLEN(XLEN)) u_ld (
    .i_data   (mem_rsp_data),
    .i_off    (w_off),
    .i_funct3 (w_f3),
    .o_data   (w_ld_data),
    .o_legal  (w_ld_legal)
  );

  assign req.in_ready = (r_state == IDLE);
  assign busy         = (r_state == WAIT_MEM);

  always_comb begin
    w_next     = r_state;
    w_complete = 1'b0;
    w_is_load  = 1'b0;
    w_latch    = 1'b0;
    w_rw       = 1'b0;
    w_rd       = req.in_rd;
    w_f3       = req.in_funct3;
    w_off      = req.in_alu_res[OW-1:0];
    unique case (r_state)
      IDLE: begin
        if (req.in_valid) begin
          w_rw = req.in_control.reg_write;
          if (req.in_control.mem_read) begin
            w_is_load = 1'b1;
            if (mem_rsp_valid) begin
              w_complete = 1'b1;
            end else begin
              w_latch = 1'b1;
              w_next  = WAIT_MEM;
            end
          end else begin
            w_complete = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        w_rd      = r_rd;
        w_f3      = r_f3;
        w_off     = r_off;
        w_rw      = r_rw;
        w_is_load = 1'b1;
        if (mem_rsp_valid) begin
          w_complete = 1'b1;
          w_next     = IDLE;
        end
      end
    endcase
  end

  assign w_alu_data = req.in_control.wb_pc
                    ? req.in_pc + XLEN'(PC_STEP)
                    : req.in_alu_res;
  assign w_data = w_is_load ? w_ld_data : w_alu_data;

`ifdef WB_MISALIGN_TRAP_EN
  assign w_mis = w_complete & w_is_load & w_ld_legal
               & f3_misaligned(w_f3, 3'(w_off));
`else
  assign w_mis = 1'b0;
`endif

  assign w_wr = w_complete & w_rw & (w_rd != '0)
              & (~w_is_load | w_ld_legal) & ~w_mis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rd    <= '0;
      r_f3    <= '0;
      r_off   <= '0;
      r_rw    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_rd  <= req.in_rd;
        r_f3  <= req.in_funct3;
        r_off <= req.in_alu_res[OW-1:0];
        r_rw  <= req.in_control.reg_write;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_we   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
    end else begin
      r_rd_we <= w_wr;
      if (w_wr) begin
        r_rd_addr <= w_rd;
        r_rd_data <= w_data;
      end
    end
  end

`ifdef WB_MISALIGN_TRAP_EN
  logic r_trap;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_trap <= 1'b0;
    else      r_trap <= w_mis;
  end
  assign trap_misalign = r_trap;
`endif

  assign rd_we   = r_rd_we;
  assign rd_addr = r_rd_addr;
  assign rd_data = r_rd_data;

endmodule
